// File: rtl/bcd_counter_ndigit.sv
// Multi-digit BCD up/down counter with a free-running tick prescaler,
// parallel BCD load, wrap pulse and per-digit active-low 7-segment decode.
module bcd_counter_ndigit #(
  parameter int DIGITS   = 4,
  parameter int DIV_EXP  = 22,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [7*DIGITS-1:0] seg7_out,
  output logic                wrap,
  output logic                tick
);

  // Active-low segment pattern, bit0=a .. bit6=g.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Non-decimal nibbles are forced to zero so the count never leaves BCD.
  function automatic logic [3:0] sanitize_digit(input logic [3:0] digit);
    logic [3:0] clean;
    if (digit > 4'd9) begin
      clean = 4'd0;
    end else begin
      clean = digit;
    end
    return clean;
  endfunction

  logic [DIV_EXP-1:0]  prescaler_r;
  logic [4*DIGITS-1:0] count_r;
  logic                wrap_r;
  logic                tick_s;
  logic                step_s;
  logic [4*DIGITS-1:0] load_clean_s;
  logic [4*DIGITS-1:0] step_next_s;
  logic                carry_s;
  logic [3:0]          digit_s;
  logic [7*DIGITS-1:0] seg_s;
  logic                zero_above_s;

  assign tick_s = &prescaler_r;
  assign step_s = enable & tick_s;

  // Free-running prescaler; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + DIV_EXP'(1);
    end
  end

  // Load value with invalid digits replaced by zero.
  always_comb begin
    load_clean_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clean_s[4*i +: 4] = sanitize_digit(load_val[4*i +: 4]);
    end
  end

  // Ripple carry/borrow chain; carry surviving the top digit marks a wrap.
  always_comb begin
    step_next_s = count_r;
    carry_s     = 1'b1;
    digit_s     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = count_r[4*i +: 4];
      if (carry_s) begin
        if (up_dn) begin
          if (digit_s == 4'd9) begin
            step_next_s[4*i +: 4] = 4'd0;
          end else begin
            step_next_s[4*i +: 4] = digit_s + 4'd1;
            carry_s               = 1'b0;
          end
        end else begin
          if (digit_s == 4'd0) begin
            step_next_s[4*i +: 4] = 4'd9;
          end else begin
            step_next_s[4*i +: 4] = digit_s - 4'd1;
            carry_s               = 1'b0;
          end
        end
      end else begin
        step_next_s[4*i +: 4] = digit_s;
      end
    end
  end

  // Count and wrap registers: load beats step beats hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      wrap_r  <= 1'b0;
    end else if (load) begin
      count_r <= load_clean_s;
      wrap_r  <= 1'b0;
    end else if (step_s) begin
      count_r <= step_next_s;
      wrap_r  <= carry_s;
    end else begin
      count_r <= count_r;
      wrap_r  <= 1'b0;
    end
  end

  // Decode from the top digit down so leading zeros can be blanked.
  always_comb begin
    seg_s        = '1;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (count_r[4*i +: 4] == 4'd0);
      if (BLANK_LZ && (i > 0) && zero_above_s) begin
        seg_s[7*i +: 7] = 7'b1111111;
      end else begin
        seg_s[7*i +: 7] = seg_decode(count_r[4*i +: 4]);
      end
    end
  end

  assign count_bcd = count_r;
  assign wrap      = wrap_r;
  assign tick      = tick_s;
  assign seg7_out  = seg_s;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Randomised and directed checks of bcd_counter_ndigit (3 digits, 4-clock tick)
// against an integer-arithmetic reference model; two instances cover both blanking modes.
module tb_bcd_counter_ndigit;

  localparam int DIGITS  = 3;
  localparam int DIV_EXP = 2;
  localparam int MODV    = 1000;
  localparam int PMAX    = 3;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk;
  logic        reset;
  logic        enable;
  logic        up_dn;
  logic        load;
  logic [11:0] load_val;
  logic [11:0] count_bcd, count2;
  logic [20:0] seg_plain, seg_blank;
  logic        wrap, wrap2, tick, tick2;

  int n_cmp = 0;
  int n_err = 0;

  int m_cnt  = 0;
  int m_pre  = 0;
  bit m_wrap = 1'b0;

  bcd_counter_ndigit #(.DIGITS(DIGITS), .DIV_EXP(DIV_EXP), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_bcd(count_bcd), .seg7_out(seg_plain),
    .wrap(wrap), .tick(tick));

  bcd_counter_ndigit #(.DIGITS(DIGITS), .DIV_EXP(DIV_EXP), .BLANK_LZ(1'b1)) dut_blank (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_bcd(count2), .seg7_out(seg_blank),
    .wrap(wrap2), .tick(tick2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [11:0] lv);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic logic [20:0] exp_seg(input int v, input bit blank);
    logic [20:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (blank && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
      else                         r[7*i +: 7] = SEG_TAB[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: the count as a plain integer modulo 10^DIGITS.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  = 0;
      m_pre  = 0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (load) begin
        m_cnt = from_load(load_val);
      end else if (enable && m_pre == PMAX) begin
        if (up_dn) begin
          m_wrap = (m_cnt == MODV - 1);
          m_cnt  = (m_cnt + 1) % MODV;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MODV - 1) % MODV;
        end
      end
      m_pre = (m_pre + 1) % (1 << DIV_EXP);
    end
  end

  task automatic apply_load(input logic [11:0] v);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (count_bcd !== 12'h000) begin n_err++; $display("FAIL reset_count: got %h want 000", count_bcd); end
    n_cmp++; if (wrap !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL reset_wrap_tick: got %b%b want 00", wrap, tick); end
    n_cmp++; if (seg_plain !== {7'h40, 7'h40, 7'h40}) begin n_err++; $display("FAIL reset_seg: got %h want %h", seg_plain, {7'h40, 7'h40, 7'h40}); end
    n_cmp++; if (seg_blank !== {7'h7F, 7'h7F, 7'h40}) begin n_err++; $display("FAIL reset_seg_blank: got %h want %h", seg_blank, {7'h7F, 7'h7F, 7'h40}); end
  endtask

  task automatic test_count_up;
    int first_tick;
    first_tick = -1;
    enable = 1'b1;
    up_dn  = 1'b1;
    reset  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (tick === 1'b1 && first_tick < 0) first_tick = k;
      n_cmp++; if (count_bcd !== to_bcd(m_cnt)) begin n_err++; $display("FAIL up_count: got %h want %h", count_bcd, to_bcd(m_cnt)); end
      n_cmp++; if (tick !== (m_pre == PMAX)) begin n_err++; $display("FAIL up_tick: got %b want %b", tick, m_pre == PMAX); end
    end
    n_cmp++; if (first_tick !== 3) begin n_err++; $display("FAIL first_tick: got %0d want 3", first_tick); end
    n_cmp++; if (count_bcd !== 12'h003) begin n_err++; $display("FAIL up_after_3_ticks: got %h want 003", count_bcd); end
  endtask

  task automatic test_wrap_up;
    int wraps;
    wraps  = 0;
    enable = 1'b1;
    up_dn  = 1'b1;
    apply_load(12'h998);
    n_cmp++; if (count_bcd !== 12'h998) begin n_err++; $display("FAIL load_998: got %h want 998", count_bcd); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (wrap === 1'b1) wraps++;
      n_cmp++; if (count_bcd !== to_bcd(m_cnt) || wrap !== m_wrap) begin n_err++; $display("FAIL wrap_up_seq: got %h/%b want %h/%b", count_bcd, wrap, to_bcd(m_cnt), m_wrap); end
      if (m_wrap) begin
        n_cmp++; if (count_bcd !== 12'h000) begin n_err++; $display("FAIL wrap_up_zero: got %h want 000", count_bcd); end
      end
    end
    n_cmp++; if (wraps !== 1) begin n_err++; $display("FAIL wrap_pulse_width: got %0d want 1", wraps); end
  endtask

  task automatic test_down;
    int k;
    enable = 1'b1;
    up_dn  = 1'b0;
    apply_load(12'h100);
    k = 0;
    do begin @(negedge clk); k++; end while (count_bcd === 12'h100 && k < 8);
    n_cmp++; if (count_bcd !== 12'h099) begin n_err++; $display("FAIL borrow_100: got %h want 099", count_bcd); end
    apply_load(12'h000);
    k = 0;
    do begin @(negedge clk); k++; end while (count_bcd === 12'h000 && k < 8);
    n_cmp++; if (count_bcd !== 12'h999 || wrap !== 1'b1) begin n_err++; $display("FAIL wrap_down: got %h/%b want 999/1", count_bcd, wrap); end
    @(negedge clk);
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL wrap_down_clear: got %b want 0", wrap); end
  endtask

  task automatic test_invalid_load;
    enable = 1'b0;
    apply_load(12'h9A5);
    n_cmp++; if (count_bcd !== 12'h905) begin n_err++; $display("FAIL load_9A5: got %h want 905", count_bcd); end
    apply_load(12'hF3C);
    n_cmp++; if (count_bcd !== 12'h030) begin n_err++; $display("FAIL load_F3C: got %h want 030", count_bcd); end
  endtask

  task automatic test_load_on_tick;
    int k;
    enable = 1'b1;
    up_dn  = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (tick !== 1'b1 && k < 8);
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL tick_timeout: got %b want 1", tick); end
    load     = 1'b1;
    load_val = 12'h123;
    @(negedge clk);
    load = 1'b0;
    n_cmp++; if (count_bcd !== 12'h123 || wrap !== 1'b0) begin n_err++; $display("FAIL load_beats_step: got %h/%b want 123/0", count_bcd, wrap); end
  endtask

  task automatic test_hold;
    int ticks;
    ticks = 0;
    apply_load(12'h456);
    enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      up_dn = 1'($urandom);
      @(negedge clk);
      if (tick === 1'b1) ticks++;
      n_cmp++; if (count_bcd !== 12'h456) begin n_err++; $display("FAIL hold_count: got %h want 456", count_bcd); end
    end
    n_cmp++; if (ticks !== 2) begin n_err++; $display("FAIL hold_ticks: got %0d want 2", ticks); end
  endtask

  task automatic test_blanking;
    enable = 1'b0;
    apply_load(12'h007);
    n_cmp++; if (seg_blank !== {7'h7F, 7'h7F, 7'h78}) begin n_err++; $display("FAIL blank_007: got %h want %h", seg_blank, {7'h7F, 7'h7F, 7'h78}); end
    n_cmp++; if (seg_plain !== {7'h40, 7'h40, 7'h78}) begin n_err++; $display("FAIL plain_007: got %h want %h", seg_plain, {7'h40, 7'h40, 7'h78}); end
    apply_load(12'h000);
    n_cmp++; if (seg_blank !== {7'h7F, 7'h7F, 7'h40}) begin n_err++; $display("FAIL blank_000: got %h want %h", seg_blank, {7'h7F, 7'h7F, 7'h40}); end
    n_cmp++; if (count2 !== 12'h000) begin n_err++; $display("FAIL blank_count: got %h want 000", count2); end
    apply_load(12'h305);
    n_cmp++; if (seg_blank !== exp_seg(305, 1'b1)) begin n_err++; $display("FAIL blank_305: got %h want %h", seg_blank, exp_seg(305, 1'b1)); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n_cmp++; if (count_bcd !== to_bcd(m_cnt) || count2 !== to_bcd(m_cnt)) begin n_err++; $display("FAIL rnd_count: got %h/%h want %h", count_bcd, count2, to_bcd(m_cnt)); end
      n_cmp++; if (wrap !== m_wrap || wrap2 !== m_wrap) begin n_err++; $display("FAIL rnd_wrap: got %b/%b want %b", wrap, wrap2, m_wrap); end
      n_cmp++; if (tick !== (m_pre == PMAX) || tick2 !== (m_pre == PMAX)) begin n_err++; $display("FAIL rnd_tick: got %b/%b want %b", tick, tick2, m_pre == PMAX); end
      n_cmp++; if (seg_plain !== exp_seg(m_cnt, 1'b0) || seg_blank !== exp_seg(m_cnt, 1'b1)) begin n_err++; $display("FAIL rnd_seg: got %h/%h want %h/%h", seg_plain, seg_blank, exp_seg(m_cnt, 1'b0), exp_seg(m_cnt, 1'b1)); end
      load     = ($urandom_range(0, 15) == 0);
      load_val = 12'($urandom);
      if ($urandom_range(0, 3) == 0) load_val = to_bcd($urandom_range(0, 2) == 0 ? 999 : 0);
      enable   = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom);
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid;
    int k;
    enable = 1'b1;
    up_dn  = 1'b1;
    apply_load(12'h456);
    repeat (2) @(negedge clk);
    load     = 1'b1;
    load_val = 12'h321;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (count_bcd !== 12'h000 || wrap !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL mid_reset: got %h/%b/%b want 000/0/0", count_bcd, wrap, tick); end
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    n_cmp++; if (count_bcd !== 12'h000) begin n_err++; $display("FAIL reset_load_lost: got %h want 000", count_bcd); end
    k = 0;
    do begin @(negedge clk); k++; end while (tick !== 1'b1 && k < 10);
    n_cmp++; if (k !== 3) begin n_err++; $display("FAIL tick_after_reset: got %0d want 3", k); end
  endtask

  initial begin
    enable   = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 12'h000;
    test_reset;
    test_count_up;
    test_wrap_up;
    test_down;
    test_invalid_load;
    test_load_on_tick;
    test_hold;
    test_blanking;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
